// File: rtl/jtag_debug_cmd_bridge.sv
// System-clock half of the CPU debug slave: synchronises TCK update strobes and queues DR scans per IR channel.
// Strobe reaches the outputs SYNC_STAGES+1 edges after it is first sampled; the head waits on its own channel's ready; a full FIFO drops and flags overrun.
module jtag_debug_cmd_bridge #(
  parameter  int DR_W        = 38,
  parameter  int IR_W        = 2,
  parameter  int SYNC_STAGES = 2,
  parameter  int DEPTH       = 4,
  localparam int NCH         = 2**IR_W,
  localparam int CNT_W       = $clog2(DEPTH+1),
  localparam int PTR_W       = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             vs_udr,
  input  logic             vs_uir,
  input  logic [IR_W-1:0]  ir_in,
  input  logic [DR_W-1:0]  sr,
  output logic [NCH-1:0]   cmd_valid,
  input  logic [NCH-1:0]   cmd_ready,
  output logic [DR_W-1:0]  jdo,
  output logic [IR_W-1:0]  cmd_ir,
  output logic             ir_update,
  output logic [CNT_W-1:0] cmd_count,
  output logic             overrun,
  input  logic             clr_overrun
);

  typedef struct packed {
    logic [IR_W-1:0] ir;
    logic [DR_W-1:0] dat;
  } cmd_t;

  logic [SYNC_STAGES-1:0] r_udr_sync;
  logic [SYNC_STAGES-1:0] r_uir_sync;
  logic                   r_udr_dly;
  logic                   r_uir_dly;
  logic [SYNC_STAGES:0]   r_live;
  logic                   w_udr_evt;
  logic                   w_uir_evt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_udr_sync <= '0;
      r_uir_sync <= '0;
      r_udr_dly  <= 1'b0;
      r_uir_dly  <= 1'b0;
      r_live     <= '0;
    end else begin
      r_udr_sync <= {r_udr_sync[SYNC_STAGES-2:0], vs_udr};
      r_uir_sync <= {r_uir_sync[SYNC_STAGES-2:0], vs_uir};
      r_udr_dly  <= r_udr_sync[SYNC_STAGES-1];
      r_uir_dly  <= r_uir_sync[SYNC_STAGES-1];
      r_live     <= {r_live[SYNC_STAGES-1:0], 1'b1};
    end
  end

  // An edge only counts once the delay flop holds a real post-reset sample, so a strobe held high through reset is not an event.
  assign w_udr_evt = r_udr_sync[SYNC_STAGES-1] & ~r_udr_dly & r_live[SYNC_STAGES];
  assign w_uir_evt = r_uir_sync[SYNC_STAGES-1] & ~r_uir_dly & r_live[SYNC_STAGES];

  cmd_t             r_mem [DEPTH];
  cmd_t             r_last;
  cmd_t             w_head;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [IR_W-1:0]  r_ir;
  logic             r_ir_update;
  logic             r_overrun;
  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;

  assign w_head    = r_mem[r_rd_ptr];
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign cmd_valid = w_empty ? '0 : (NCH'(1) << w_head.ir);
  assign w_pop     = |(cmd_valid & cmd_ready);
  assign w_push    = w_udr_evt & (~w_full | w_pop);
  assign w_drop    = w_udr_evt & w_full & ~w_pop;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {r_ir, sr};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_last      <= '0;
      r_ir        <= '0;
      r_ir_update <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        r_last   <= w_head;
      end
      if (w_push && !w_pop) r_count <= r_count + CNT_W'(1);
      else if (!w_push && w_pop) r_count <= r_count - CNT_W'(1);
      if (w_drop) r_overrun <= 1'b1;
      else if (clr_overrun) r_overrun <= 1'b0;
      r_ir_update <= w_uir_evt;
      if (w_uir_evt) r_ir <= ir_in;
    end
  end

  // When empty the outputs keep showing the most recently consumed command.
  assign jdo       = w_empty ? r_last.dat : w_head.dat;
  assign cmd_ir    = w_empty ? r_last.ir : w_head.ir;
  assign cmd_count = r_count;
  assign overrun   = r_overrun;
  assign ir_update = r_ir_update;

endmodule
